// File: rtl/neuron_backprop_if.sv
// Operand/result bundle for neuron_backprop: input valid/ready handshake,
// forward-pass operands, output valid/ready handshake and all gradient results.
interface neuron_backprop_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] z;
  logic [31:0] delta_in;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [31:0] w1;
  logic [31:0] w2;
  logic [31:0] b;
  logic [31:0] lr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] grad;
  logic [31:0] dw1;
  logic [31:0] dw2;
  logic [31:0] db;
  logic [31:0] dx1;
  logic [31:0] dx2;
  logic [31:0] w1_new;
  logic [31:0] w2_new;
  logic [31:0] b_new;

  modport master (
    output in_valid, z, delta_in, x1, x2, w1, w2, b, lr, out_ready,
    input  in_ready, out_valid, grad, dw1, dw2, db, dx1, dx2, w1_new, w2_new, b_new
  );

  modport slave (
    input  in_valid, z, delta_in, x1, x2, w1, w2, b, lr, out_ready,
    output in_ready, out_valid, grad, dw1, dw2, db, dx1, dx2, w1_new, w2_new, b_new
  );
endinterface

// File: rtl/neuron_backprop.sv
// Backward pass of the 2-input fast-sigmoid neuron in signed Q16.16 with SGD update.
// Optional macro GRAD_CLIP_EN clamps the local gradient to +/-CLIP_LIMIT.
module neuron_backprop #(
  parameter logic signed [31:0] CLIP_LIMIT = 32'sd65536
) (
  input  logic            clk,
  input  logic            rst_n,
  neuron_backprop_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIV  = 3'd1;
  localparam logic [2:0] S_SQR  = 3'd2;
  localparam logic [2:0] S_GRAD = 3'd3;
  localparam logic [2:0] S_PROD = 3'd4;
  localparam logic [2:0] S_UPD  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [4:0] DIV_LAST = 5'd17;

`ifdef GRAD_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  localparam logic signed [65:0] SAT_MAX = 66'sd2147483647;
  localparam logic signed [65:0] SAT_MIN = -66'sd2147483648;

  function automatic logic signed [31:0] sat32(input logic signed [65:0] v);
    if (v > SAT_MAX)
      return 32'sh7FFF_FFFF;
    else if (v < SAT_MIN)
      return 32'sh8000_0000;
    else
      return v[31:0];
  endfunction

  // Q16.16 product: full 64-bit signed product, floor shift, saturate.
  function automatic logic signed [31:0] qmul(input logic signed [31:0] a,
                                              input logic signed [31:0] c);
    logic signed [63:0] ae;
    logic signed [63:0] ce;
    logic signed [63:0] p;
    logic signed [65:0] sh;
    ae = a;
    ce = c;
    p  = ae * ce;
    sh = p >>> 16;
    return sat32(sh);
  endfunction

  // w - lr*d with lr treated as unsigned.
  function automatic logic signed [31:0] sgd(input logic signed [31:0] w,
                                             input logic        [31:0] lr_u,
                                             input logic signed [31:0] d);
    logic signed [65:0] le;
    logic signed [65:0] de;
    logic signed [65:0] p;
    logic signed [31:0] step;
    logic signed [65:0] we;
    logic signed [65:0] se;
    le   = {34'b0, lr_u};
    de   = d;
    p    = le * de;
    step = sat32(p >>> 16);
    we   = w;
    se   = step;
    return sat32(we - se);
  endfunction

  logic [2:0]         state_reg;
  logic [2:0]         state_next;
  logic [4:0]         cnt_reg;

  logic signed [31:0] z_reg;
  logic signed [31:0] delta_reg;
  logic signed [31:0] b_reg;
  logic [31:0]        lr_reg;
  logic signed [31:0] op_reg [4];    // x1, x2, w1, w2

  logic [32:0]        den_reg;
  logic [32:0]        rem_reg;
  logic [16:0]        quo_reg;
  logic [15:0]        h_reg;

  logic signed [31:0] grad_reg;
  logic signed [31:0] prod_reg [4];  // dw1, dw2, dx1, dx2
  logic signed [31:0] upd_reg [3];   // w1_new, w2_new, b_new

  logic [31:0]        abs_z;
  logic [32:0]        den_init;
  logic [33:0]        rem_shift;
  logic               rem_ge;
  logic [33:0]        sq;
  logic signed [31:0] g_raw;
  logic signed [31:0] g_clip;
  logic signed [31:0] mul_p [4];
  logic signed [31:0] upd_w [3];
  logic signed [31:0] upd_d [3];
  logic signed [31:0] upd_p [3];

  // |z| saturates so the most negative input cannot overflow the divisor.
  always_comb begin
    abs_z = z_reg;
    if (z_reg == 32'sh8000_0000)
      abs_z = 32'h7FFF_FFFF;
    else if (z_reg[31])
      abs_z = -z_reg;
  end

  assign den_init  = 33'd65536 + {1'b0, abs_z};
  assign rem_shift = {rem_reg, 1'b0};
  assign rem_ge    = (rem_shift >= {1'b0, den_reg});
  assign sq        = {17'b0, quo_reg} * {17'b0, quo_reg};

  assign g_raw = qmul(delta_reg, $signed({16'b0, h_reg}));

  always_comb begin
    g_clip = g_raw;
    if (CLIP_ON) begin
      if (g_raw > CLIP_LIMIT)
        g_clip = CLIP_LIMIT;
      else if (g_raw < -CLIP_LIMIT)
        g_clip = -CLIP_LIMIT;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_prod
      assign mul_p[gi] = qmul(grad_reg, op_reg[gi]);
    end
  endgenerate

  assign upd_w[0] = op_reg[2];
  assign upd_w[1] = op_reg[3];
  assign upd_w[2] = b_reg;
  assign upd_d[0] = prod_reg[0];
  assign upd_d[1] = prod_reg[1];
  assign upd_d[2] = grad_reg;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_upd
      assign upd_p[gi] = sgd(upd_w[gi], lr_reg, upd_d[gi]);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.in_valid) state_next = S_DIV;
      S_DIV:   if (cnt_reg == DIV_LAST) state_next = S_SQR;
      S_SQR:   state_next = S_GRAD;
      S_GRAD:  state_next = S_PROD;
      S_PROD:  state_next = S_UPD;
      S_UPD:   state_next = S_DONE;
      S_DONE:  if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      z_reg     <= '0;
      delta_reg <= '0;
      b_reg     <= '0;
      lr_reg    <= '0;
      den_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      h_reg     <= '0;
      grad_reg  <= '0;
      for (int i = 0; i < 4; i++) begin
        op_reg[i]   <= '0;
        prod_reg[i] <= '0;
      end
      for (int i = 0; i < 3; i++)
        upd_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid) begin
            z_reg     <= bus.z;
            delta_reg <= bus.delta_in;
            op_reg[0] <= bus.x1;
            op_reg[1] <= bus.x2;
            op_reg[2] <= bus.w1;
            op_reg[3] <= bus.w2;
            b_reg     <= bus.b;
            lr_reg    <= bus.lr;
            cnt_reg   <= '0;
          end
        end
        S_DIV: begin
          // First DIV cycle latches the divisor; the next 17 each retire one
          // quotient bit of 2^32/den. Starting remainder is 2^32 >> 17.
          if (cnt_reg == 5'd0) begin
            den_reg <= den_init;
            rem_reg <= 33'd32768;
            quo_reg <= '0;
          end else begin
            rem_reg <= rem_ge ? 33'(rem_shift - {1'b0, den_reg}) : 33'(rem_shift);
            quo_reg <= {quo_reg[15:0], rem_ge};
          end
          cnt_reg <= cnt_reg + 5'd1;
        end
        S_SQR: begin
          h_reg <= 16'(sq >> 17);
        end
        S_GRAD: begin
          grad_reg <= g_clip;
        end
        S_PROD: begin
          for (int i = 0; i < 4; i++)
            prod_reg[i] <= mul_p[i];
        end
        S_UPD: begin
          for (int i = 0; i < 3; i++)
            upd_reg[i] <= upd_p[i];
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.out_valid = (state_reg == S_DONE);
  assign bus.grad      = grad_reg;
  assign bus.db        = grad_reg;
  assign bus.dw1       = prod_reg[0];
  assign bus.dw2       = prod_reg[1];
  assign bus.dx1       = prod_reg[2];
  assign bus.dx2       = prod_reg[3];
  assign bus.w1_new    = upd_reg[0];
  assign bus.w2_new    = upd_reg[1];
  assign bus.b_new     = upd_reg[2];

endmodule

// File: tb/tb_neuron_backprop.sv
// Directed self-checking bench for neuron_backprop; one task per scenario.
module tb_neuron_backprop;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_backprop_if bus();

  neuron_backprop #(.CLIP_LIMIT(32'sd16384)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] MONE = 32'hFFFF_0000;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] obs [9];
  string onames [9] = '{"grad", "dw1", "dw2", "db", "dx1", "dx2", "w1_new", "w2_new", "b_new"};

  always_comb begin
    obs[0] = bus.grad;
    obs[1] = bus.dw1;
    obs[2] = bus.dw2;
    obs[3] = bus.db;
    obs[4] = bus.dx1;
    obs[5] = bus.dx2;
    obs[6] = bus.w1_new;
    obs[7] = bus.w2_new;
    obs[8] = bus.b_new;
  end

  task automatic drive(input logic [31:0] z, d, x1, x2, w1, w2, b, lr);
    bus.z        = z;
    bus.delta_in = d;
    bus.x1       = x1;
    bus.x2       = x2;
    bus.w1       = w1;
    bus.w2       = w2;
    bus.b        = b;
    bus.lr       = lr;
  endtask

  // Presents one operand set, waits for acceptance, returns edges until out_valid (0 = timeout).
  task automatic run_op(input logic [31:0] z, d, x1, x2, w1, w2, b, lr, output int lat);
    int k;
    @(negedge clk);
    drive(z, d, x1, x2, w1, w2, b, lr);
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset in_ready: got %b expected 1", bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset out_valid: got %b expected 0", bus.out_valid);
    end
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (obs[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset %s: got 0x%08h expected 0x00000000", onames[i], obs[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: outputs cleared, in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
  endtask

  task automatic test_nominal();
    int lat;
    logic [31:0] ex [9];
    ex = '{32'sd32768, 32'sd65536, 32'sd32768, 32'sd32768, 32'sd32768,
           -32'sd32768, 32'sd32768, -32'sd81920, -32'sd16384};
    run_op(32'h0, ONE, 32'd131072, ONE, ONE, MONE, 32'h0, 32'd32768, lat);
    n_checks++;
    if (lat !== 22) begin
      n_fail++;
      $display("FAIL nominal latency: got %0d expected 22", lat);
    end
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (obs[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL nominal %s: got 0x%08h expected 0x%08h", onames[i], obs[i], ex[i]);
      end
    end
    // out_ready on the first DONE cycle: exactly one cycle of out_valid
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal single_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal in_ready_after: got %b expected 1", bus.in_ready);
    end
    bus.out_ready = 1'b0;
    $display("nominal: latency=%0d grad=%0d w2_new=%0d", lat, $signed(obs[0]), $signed(obs[7]));
  endtask

  task automatic test_symmetry();
    logic [31:0] zt [3];
    logic [31:0] dt [3];
    logic [31:0] gt [3];
    int lat;
    zt = '{ONE, MONE, 32'h0};
    dt = '{ONE, ONE, MONE};
    gt = '{32'sd8192, 32'sd8192, -32'sd32768};
    for (int r = 0; r < 3; r++) begin
      run_op(zt[r], dt[r], ONE, 32'h0, ONE, 32'h0, 32'h0, 32'h0, lat);
      n_checks++;
      if (bus.grad !== gt[r]) begin
        n_fail++;
        $display("FAIL symmetry[%0d] grad: got 0x%08h expected 0x%08h", r, bus.grad, gt[r]);
      end
      n_checks++;
      if (bus.dw1 !== gt[r]) begin
        n_fail++;
        $display("FAIL symmetry[%0d] dw1: got 0x%08h expected 0x%08h", r, bus.dw1, gt[r]);
      end
      n_checks++;
      if (bus.w1_new !== ONE) begin
        n_fail++;
        $display("FAIL symmetry[%0d] w1_new: got 0x%08h expected 0x%08h", r, bus.w1_new, ONE);
      end
      $display("symmetry[%0d]: z=0x%08h grad=%0d latency=%0d", r, zt[r], $signed(bus.grad), lat);
      release_out();
    end
  endtask

  task automatic test_saturation();
    int lat;
    run_op(32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'h0, 32'h0, ONE, lat);
    n_checks++;
    if (bus.grad !== 32'h3FFF_FFFF) begin
      n_fail++;
      $display("FAIL sat grad: got 0x%08h expected 0x3fffffff", bus.grad);
    end
    n_checks++;
    if (bus.dw1 !== 32'h7FFF_FFFF) begin
      n_fail++;
      $display("FAIL sat dw1: got 0x%08h expected 0x7fffffff", bus.dw1);
    end
    n_checks++;
    if (bus.dx1 !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL sat dx1: got 0x%08h expected 0x80000000", bus.dx1);
    end
    n_checks++;
    if (bus.w1_new !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL sat w1_new: got 0x%08h expected 0x80000000", bus.w1_new);
    end
    n_checks++;
    if (bus.b_new !== 32'hC000_0001) begin
      n_fail++;
      $display("FAIL sat b_new: got 0x%08h expected 0xc0000001", bus.b_new);
    end
    $display("sat: grad=0x%08h dw1=0x%08h w1_new=0x%08h", bus.grad, bus.dw1, bus.w1_new);
    release_out();

    run_op(32'h8000_0000, ONE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, lat);
    n_checks++;
    if (lat !== 22) begin
      n_fail++;
      $display("FAIL zmin latency: got %0d expected 22", lat);
    end
    n_checks++;
    if (bus.grad !== 32'h0) begin
      n_fail++;
      $display("FAIL zmin grad: got 0x%08h expected 0x00000000", bus.grad);
    end
    $display("zmin: grad=0x%08h latency=%0d", bus.grad, lat);
    release_out();

    run_op(32'h0, ONE, ONE, 32'h0, 32'd12345, 32'h0, 32'hFFFF_FCF7, 32'h0, lat);
    n_checks++;
    if (bus.w1_new !== 32'd12345) begin
      n_fail++;
      $display("FAIL lr0 w1_new: got 0x%08h expected 0x%08h", bus.w1_new, 32'd12345);
    end
    n_checks++;
    if (bus.b_new !== 32'hFFFF_FCF7) begin
      n_fail++;
      $display("FAIL lr0 b_new: got 0x%08h expected 0xfffffcf7", bus.b_new);
    end
    n_checks++;
    if (bus.dw1 !== 32'd32768) begin
      n_fail++;
      $display("FAIL lr0 dw1: got 0x%08h expected 0x00008000", bus.dw1);
    end
    $display("lr0: w1_new=%0d b_new=%0d", $signed(bus.w1_new), $signed(bus.b_new));
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] ex [9];
    ex = '{32'sd32768, 32'sd65536, 32'sd32768, 32'sd32768, 32'sd32768,
           -32'sd32768, 32'sd32768, -32'sd81920, -32'sd16384};
    run_op(32'h0, ONE, 32'd131072, ONE, ONE, MONE, 32'h0, 32'd32768, lat);
    // a competing operand set must be ignored while results are pending
    drive(ONE, ONE, ONE, ONE, ONE, ONE, ONE, ONE);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp[%0d] handshake: got valid=%b ready=%b expected valid=1 ready=0",
                 c, bus.out_valid, bus.in_ready);
      end
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (obs[i] !== ex[i]) begin
          n_fail++;
          $display("FAIL bp[%0d] %s: got 0x%08h expected 0x%08h", c, onames[i], obs[i], ex[i]);
        end
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp release out_valid: got %b expected 0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp release in_ready: got %b expected 1", bus.in_ready);
    end
    $display("backpressure: held 5 cycles, released, in_ready=%b", bus.in_ready);
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    drive(32'h0, ONE, 32'd131072, ONE, ONE, MONE, 32'h0, 32'd32768);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset handshake: got valid=%b ready=%b expected valid=0 ready=1",
               bus.out_valid, bus.in_ready);
    end
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (obs[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL midreset %s: got 0x%08h expected 0x00000000", onames[i], obs[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0, ONE, 32'd131072, ONE, ONE, MONE, 32'h0, 32'd32768, lat);
    n_checks++;
    if (lat !== 22) begin
      n_fail++;
      $display("FAIL midreset latency: got %0d expected 22", lat);
    end
    n_checks++;
    if (bus.grad !== 32'd32768 || bus.w2_new !== 32'hFFFE_C000) begin
      n_fail++;
      $display("FAIL midreset result: got grad=0x%08h w2_new=0x%08h expected 0x00008000 0xfffec000",
               bus.grad, bus.w2_new);
    end
    $display("midreset: recovered latency=%0d grad=%0d", lat, $signed(bus.grad));
    release_out();
  endtask

  task automatic test_grad_clip();
    int lat;
    logic [31:0] eg;
    logic [31:0] edw;
`ifdef GRAD_CLIP_EN
    eg  = 32'd16384;
    edw = 32'd32768;
`else
    eg  = 32'd32768;
    edw = 32'd65536;
`endif
    run_op(32'h0, ONE, 32'd131072, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, lat);
    n_checks++;
    if (bus.grad !== eg) begin
      n_fail++;
      $display("FAIL clip grad: got 0x%08h expected 0x%08h", bus.grad, eg);
    end
    n_checks++;
    if (bus.dw1 !== edw) begin
      n_fail++;
      $display("FAIL clip dw1: got 0x%08h expected 0x%08h", bus.dw1, edw);
    end
    n_checks++;
    if (lat !== 22) begin
      n_fail++;
      $display("FAIL clip latency: got %0d expected 22", lat);
    end
    $display("clip: grad=%0d dw1=%0d", $signed(bus.grad), $signed(bus.dw1));
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    @(negedge clk);
    drive(32'h0, ONE, 32'd131072, ONE, ONE, MONE, 32'h0, 32'd32768);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    // second operand set held valid throughout the first operation
    drive(ONE, ONE, ONE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b in_ready_drop: got %b expected 0", bus.in_ready);
    end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat !== 22 || bus.grad !== 32'd32768 || bus.w1_new !== 32'd32768) begin
      n_fail++;
      $display("FAIL b2b first: got lat=%0d grad=0x%08h w1_new=0x%08h expected 22 0x00008000 0x00008000",
               lat, bus.grad, bus.w1_new);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b out_valid_drop: got %b expected 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b second_accept: got in_ready=%b expected 0", bus.in_ready);
    end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat !== 22 || bus.grad !== 32'd8192 || bus.dw1 !== 32'd8192) begin
      n_fail++;
      $display("FAIL b2b second: got lat=%0d grad=0x%08h dw1=0x%08h expected 22 0x00002000 0x00002000",
               lat, bus.grad, bus.dw1);
    end
    $display("back_to_back: second grad=%0d latency=%0d", $signed(bus.grad), lat);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_nominal();
    test_symmetry();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_grad_clip();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
